game_object_engine: RTL and testbench

- Upstream producer of the packed gamedata vector that the collision stage consumes.
- Owns slot 0, the player dinosaur, and runs its jump state machine.
- Owns slots 1..DATACOUNT-1, the enemy obstacles: scrolls them left, despawns them off-screen, and spawns new ones from an LFSR timer.
- Runs the game FSM (IDLE/RUN/OVER) and freezes the world when the collision stage asserts collide.

---
 rtl/game_object_engine.sv | 197 +++++++++++++++++++
 tb/tb_game_object_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_object_engine.sv
// Game object engine: player jump FSM, scrolling/spawning enemy slots and the IDLE/RUN/OVER
// game FSM, producing the packed gamedata vector consumed by the collision stage.
module game_object_engine #(
    parameter int DATACOUNT    = 4,
    parameter int XLEN         = 10,
    parameter int YLEN         = 10,
    parameter int WLEN         = 6,
    parameter int HLEN         = 6,
    parameter int TYPELEN      = 2,
    parameter int DATALEN      = XLEN + YLEN + WLEN + HLEN + TYPELEN,
    parameter int SPEED        = 4,
    parameter int SPAWN_X      = 639,
    parameter int MIN_GAP      = 24,
    parameter int PLAYER_X     = 40,
    parameter int PLAYER_W     = 16,
    parameter int PLAYER_H     = 20,
    parameter int JUMP_STEP    = 6,
    parameter int JUMP_H       = 60,
    parameter int COLLIDE_MASK = 3
) (
    input  logic                         clk3,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         start,
    input  logic                         jump,
    input  logic                         collide,
    output logic [DATALEN*DATACOUNT-1:0] gamedata,
    output logic                         gameover,
    output logic [15:0]                  score
);
    localparam int CNTW  = 8;
    localparam int MASKW = $clog2(COLLIDE_MASK + 1);
    localparam int IDXW  = $clog2(DATACOUNT);

    localparam logic [TYPELEN-1:0] TYPE_PLAYER = TYPELEN'(1);
    localparam logic [TYPELEN-1:0] TYPE_ENEMY  = TYPELEN'(2);
    localparam logic [XLEN-1:0]    SPEED_C     = XLEN'(SPEED);
    localparam logic [YLEN-1:0]    STEP_C      = YLEN'(JUMP_STEP);
    localparam logic [YLEN-1:0]    APEX_C      = YLEN'(JUMP_H);
    localparam logic [CNTW-1:0]    GAP_C       = CNTW'(MIN_GAP);
    localparam logic [MASKW-1:0]   MASK_C      = MASKW'(COLLIDE_MASK);
    localparam logic [MASKW-1:0]   MASK_ONE    = MASKW'(1);
    localparam logic [CNTW-1:0]    CNT_ONE     = CNTW'(1);

    typedef enum logic [1:0] {G_IDLE, G_RUN, G_OVER} game_state_e;
    typedef enum logic [1:0] {J_GROUND, J_RISE, J_FALL} jump_state_e;

    function automatic logic [DATALEN-1:0] make_rec(
        input logic [XLEN-1:0] x, input logic [YLEN-1:0] y, input logic [WLEN-1:0] w,
        input logic [HLEN-1:0] h, input logic [TYPELEN-1:0] t);
        return {t, h, w, y, x};
    endfunction

    localparam logic [DATALEN-1:0] PLAYER_GROUND =
        {TYPE_PLAYER, HLEN'(PLAYER_H), WLEN'(PLAYER_W), YLEN'(0), XLEN'(PLAYER_X)};

    game_state_e         game_q, game_d;
    jump_state_e         jump_q, jump_d;
    logic [MASKW-1:0]    mask_q, mask_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         score_q, score_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [DATALEN-1:0]  rec_q [DATACOUNT];
    logic [DATALEN-1:0]  rec_d [DATACOUNT];
    logic                gameover_q;

    logic                run_tick;
    logic                free_found;
    logic [IDXW-1:0]     free_idx;
    logic [CNTW-1:0]     cnt_dec;
    logic [YLEN-1:0]     player_y;
    logic [YLEN-1:0]     y_sum;

    // NOTE: every variable gets a default at the top of the block, so no path leaves a latch.
    always_comb begin
        game_d     = game_q;
        jump_d     = jump_q;
        mask_d     = (mask_q != '0) ? mask_q - MASK_ONE : mask_q;
        lfsr_d     = lfsr_q;
        score_d    = score_q;
        cnt_d      = cnt_q;
        rec_d      = rec_q;
        run_tick   = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        cnt_dec    = cnt_q;
        player_y   = rec_q[0][XLEN +: YLEN];
        y_sum      = player_y + STEP_C;

        unique case (game_q)
            G_IDLE: begin
                if (start) begin
                    game_d = G_RUN;
                    mask_d = MASK_C;
                end
            end
            G_RUN: begin
                if (collide && mask_q == '0) game_d = G_OVER;
                else                         run_tick = tick;
            end
            G_OVER: begin
                if (start) begin
                    game_d  = G_RUN;
                    mask_d  = MASK_C;
                    jump_d  = J_GROUND;
                    cnt_d   = GAP_C;
                    score_d = '0;
                    for (int i = 1; i < DATACOUNT; i++) rec_d[i] = '0;
                    rec_d[0] = PLAYER_GROUND;
                end
            end
            default: game_d = G_IDLE;
        endcase

        if (run_tick) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;

            // Free slot is chosen from the pre-tick occupancy; slots freed now wait a tick.
            for (int i = 1; i < DATACOUNT; i++) begin
                if (rec_q[i][DATALEN-1 -: TYPELEN] == TYPE_ENEMY) begin
                    if (rec_q[i][XLEN-1:0] >= SPEED_C) rec_d[i][XLEN-1:0] = rec_q[i][XLEN-1:0] - SPEED_C;
                    else                               rec_d[i] = '0;
                end else if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDXW'(i);
                end
            end

            if (cnt_q != '0) cnt_dec = cnt_q - CNT_ONE;
            cnt_d = cnt_dec;
            if (cnt_dec == '0 && free_found) begin
                rec_d[free_idx] = make_rec(XLEN'(SPAWN_X), YLEN'(0),
                                           lfsr_d[0] ? WLEN'(12) : WLEN'(8),
                                           lfsr_d[1] ? HLEN'(24) : HLEN'(16), TYPE_ENEMY);
                cnt_d = GAP_C + CNTW'(lfsr_d[6:2]);
            end

            unique case (jump_q)
                J_GROUND: begin
                    if (jump) begin
                        jump_d = J_RISE;
                        rec_d[0][XLEN +: YLEN] = y_sum;
                    end
                end
                J_RISE: begin
                    if (y_sum >= APEX_C) begin
                        jump_d = J_FALL;
                        rec_d[0][XLEN +: YLEN] = APEX_C;
                    end else begin
                        rec_d[0][XLEN +: YLEN] = y_sum;
                    end
                end
                J_FALL: begin
                    if (player_y <= STEP_C) begin
                        jump_d = J_GROUND;
                        rec_d[0][XLEN +: YLEN] = '0;
                    end else begin
                        rec_d[0][XLEN +: YLEN] = player_y - STEP_C;
                    end
                end
                default: jump_d = J_GROUND;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk3) begin
        if (reset) begin
            game_q     <= G_IDLE;
            jump_q     <= J_GROUND;
            mask_q     <= '0;
            lfsr_q     <= 16'hACE1;
            score_q    <= '0;
            cnt_q      <= GAP_C;
            gameover_q <= 1'b0;
            // NOTE: the record array is a handful of flops, not a RAM, so it is reset explicitly.
            for (int i = 0; i < DATACOUNT; i++) rec_q[i] <= (i == 0) ? PLAYER_GROUND : '0;
        end else begin
            game_q     <= game_d;
            jump_q     <= jump_d;
            mask_q     <= mask_d;
            lfsr_q     <= lfsr_d;
            score_q    <= score_d;
            cnt_q      <= cnt_d;
            gameover_q <= (game_d == G_OVER);
            for (int i = 0; i < DATACOUNT; i++) rec_q[i] <= rec_d[i];
        end
    end

    for (genvar g = 0; g < DATACOUNT; g++) begin : g_pack
        assign gamedata[g*DATALEN +: DATALEN] = rec_q[g];
    end

    assign gameover = gameover_q;
    assign score    = score_q;
endmodule

// File: tb/tb_game_object_engine.sv
// Randomized and directed bench for game_object_engine: a frame-level reference model feeds a
// scoreboard queue that a separate monitor drains one cycle at a time.
module tb_game_object_engine;
    localparam int DC        = 4;
    localparam int DL        = 34;
    localparam int GW        = DL * DC;
    localparam int SPEED     = 4;
    localparam int SPAWN_X   = 639;
    localparam int MIN_GAP   = 24;
    localparam int PLAYER_X  = 40;
    localparam int PLAYER_W  = 16;
    localparam int PLAYER_H  = 20;
    localparam int JUMP_STEP = 6;
    localparam int JUMP_H    = 60;
    localparam int MASK      = 3;
    localparam int APEX      = JUMP_H / JUMP_STEP;
    localparam logic [DL-1:0] P_GROUND = {2'd1, 6'd20, 6'd16, 10'd0, 10'd40};

    logic          clk3 = 1'b0;
    logic          reset = 1'b1, tick = 1'b0, start = 1'b0, jump = 1'b0, collide = 1'b0;
    logic [GW-1:0] gamedata;
    logic          gameover;
    logic [15:0]   score;

    game_object_engine dut (
        .clk3(clk3), .reset(reset), .tick(tick), .start(start), .jump(jump),
        .collide(collide), .gamedata(gamedata), .gameover(gameover), .score(score)
    );

    always #5 clk3 = ~clk3;

    typedef struct {
        logic [GW-1:0] gd;
        logic          go;
        logic [15:0]   sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: whole-game state as plain integers.
    int m_state;  // 0 idle, 1 run, 2 over
    int m_mask, m_lfsr, m_score, m_cnt, m_jt;
    int m_act[DC], m_x[DC], m_w[DC], m_h[DC];

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic void model_clear_world();
        for (int i = 0; i < DC; i++) m_act[i] = 0;
        m_jt    = 0;
        m_cnt   = MIN_GAP;
        m_score = 0;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_mask  = 0;
        m_lfsr  = 'hACE1;
        model_clear_world();
    endfunction

    function automatic int model_y();
        return JUMP_STEP * ((m_jt <= APEX) ? m_jt : 2 * APEX - m_jt);
    endfunction

    function automatic void model_frame(input logic j);
        int fb, free;
        fb     = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
        if (m_score < 65535) m_score++;
        free = 0;
        for (int i = DC - 1; i >= 1; i--) if (m_act[i] == 0) free = i;
        for (int i = 1; i < DC; i++) begin
            if (m_act[i] != 0) begin
                if (m_x[i] >= SPEED) m_x[i] -= SPEED;
                else                 m_act[i] = 0;
            end
        end
        if (m_cnt > 0) m_cnt--;
        if (m_cnt == 0 && free != 0) begin
            m_act[free] = 1;
            m_x[free]   = SPAWN_X;
            m_w[free]   = (m_lfsr & 1) ? 12 : 8;
            m_h[free]   = (m_lfsr & 2) ? 24 : 16;
            m_cnt       = MIN_GAP + ((m_lfsr >> 2) & 31);
        end
        if (m_jt == 0) begin
            if (j) m_jt = 1;
        end else begin
            m_jt = (m_jt + 1) % (2 * APEX);
        end
    endfunction

    function automatic void model_step(input logic r, input logic t, input logic s,
                                       input logic j, input logic c);
        int nm;
        logic adv;
        if (r) begin
            model_reset();
            return;
        end
        nm  = (m_mask > 0) ? m_mask - 1 : 0;
        adv = 1'b0;
        case (m_state)
            0: if (s) begin m_state = 1; nm = MASK; end
            1: if (c && m_mask == 0) m_state = 2; else adv = t;
            2: if (s) begin m_state = 1; nm = MASK; model_clear_world(); end
            default: m_state = 0;
        endcase
        m_mask = nm;
        if (adv) model_frame(j);
    endfunction

    function automatic logic [GW-1:0] model_gamedata();
        logic [GW-1:0] gd;
        gd = '0;
        gd[DL-1:0] = {2'd1, 6'(PLAYER_H), 6'(PLAYER_W), 10'(model_y()), 10'(PLAYER_X)};
        for (int i = 1; i < DC; i++)
            if (m_act[i] != 0) gd[i*DL +: DL] = {2'd2, 6'(m_h[i]), 6'(m_w[i]), 10'd0, 10'(m_x[i])};
        return gd;
    endfunction

    task automatic cycle(input logic r, input logic t, input logic s, input logic j, input logic c);
        exp_t e;
        @(negedge clk3);
        reset = r; tick = t; start = s; jump = j; collide = c;
        model_step(r, t, s, j, c);
        e.gd = model_gamedata();
        e.go = (m_state == 2);
        e.sc = 16'(m_score);
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk3);
        #2;
    endtask

    // Monitor: each registered update is compared with the expectation queued for it.
    initial begin
        forever begin
            @(posedge clk3);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_gamedata", gamedata, mon_e.gd);
                check("sb_gameover", GW'(gameover), GW'(mon_e.go));
                check("sb_score", GW'(score), GW'(mon_e.sc));
            end
        end
    end

    initial begin
        int saved_score;
        logic [GW-1:0] saved_gd;
        model_reset();

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        settle();
        check("reset_score", GW'(score), 0);
        check("reset_gameover", GW'(gameover), 0);
        check("reset_player", GW'(gamedata[DL-1:0]), GW'(P_GROUND));
        check("reset_enemies", GW'(gamedata[GW-1:DL]), 0);

        // Tick and jump in IDLE do nothing; then start and 24 spaced ticks.
        cycle(0, 1, 0, 1, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (24) begin
            cycle(0, 1, 0, 0, 0);
            repeat (3) cycle(0, 0, 0, 0, 0);
        end
        settle();
        check("spawn_type", GW'(gamedata[DL+32 +: 2]), 2);
        check("spawn_x", GW'(gamedata[DL +: 10]), SPAWN_X);
        check("spawn_y", GW'(gamedata[DL+10 +: 10]), 0);
        check("spawn_slots23", GW'(gamedata[GW-1:2*DL]), 0);
        check("spawn_score", GW'(score), 24);

        // Single-tick jump, with jump re-asserted mid-air.
        cycle(0, 1, 0, 1, 0);
        settle();
        check("jump_t1", GW'(gamedata[10 +: 10]), JUMP_STEP);
        for (int k = 2; k <= 20; k++) begin
            cycle(0, 1, 0, (k % 3 == 0), 0);
            if (k == 10) begin settle(); check("jump_apex", GW'(gamedata[10 +: 10]), JUMP_H); end
            if (k == 19) begin settle(); check("jump_t19", GW'(gamedata[10 +: 10]), JUMP_STEP); end
            if (k == 20) begin settle(); check("jump_land", GW'(gamedata[10 +: 10]), 0); end
        end

        // Long collision-free run: enemies despawn, slots fill, spawns retry.
        repeat (1500) cycle(0, $urandom_range(0, 3) != 0, 0, $urandom_range(0, 7) == 0, 0);

        // Fully random traffic including restarts and rare resets.
        repeat (2500)
            cycle($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) == 0);

        // Collision freezes the world; restart clears it and masks collide for 3 cycles.
        cycle(0, 0, 1, 0, 0);
        repeat (40) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        settle();
        check("over_gameover", GW'(gameover), 1);
        saved_score = m_score;
        saved_gd    = model_gamedata();
        repeat (5) cycle(0, 1, 0, 1, 0);
        settle();
        check("over_score_frozen", GW'(score), GW'(saved_score));
        check("over_world_frozen", gamedata, saved_gd);
        cycle(0, 1, 1, 0, 0);
        settle();
        check("restart_score", GW'(score), 0);
        check("restart_enemies", GW'(gamedata[GW-1:DL]), 0);
        check("restart_gameover", GW'(gameover), 0);
        repeat (3) cycle(0, 1, 0, 0, 1);
        settle();
        check("mask_gameover", GW'(gameover), 0);
        check("mask_score", GW'(score), 3);
        cycle(0, 0, 0, 0, 1);
        settle();
        check("mask_expired", GW'(gameover), 1);

        // Reset mid-jump with an enemy on screen, then replay from the reset LFSR.
        cycle(0, 0, 1, 0, 0);
        repeat (30) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        repeat (4) cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 1);
        settle();
        check("rst_gameover", GW'(gameover), 0);
        check("rst_score", GW'(score), 0);
        check("rst_player", GW'(gamedata[DL-1:0]), GW'(P_GROUND));
        check("rst_enemies", GW'(gamedata[GW-1:DL]), 0);
        cycle(0, 0, 1, 0, 0);
        repeat (60) cycle(0, 1, 0, 0, 0);

        repeat (2) @(posedge clk3);
        #3;
        check("sb_drained", GW'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
